star_scan_engine: RTL and testbench

- Parametrised raster scanner for the star-finding pipeline; successor to the fixed 160x120 scan controller.
- Walks every pixel of a frame-buffer region in row-major order and issues reads with a configurable memory latency.
- Compares each masked pixel against a threshold. On a hit it halts and holds a star_found handshake until the mapping/draw/clean chain acknowledges.
- Adds start-position load, hit counting, scan-done pulse and latency tolerance; sits between the on-chip image RAM and the star mapping FSMs.

---
 rtl/star_scan_engine_if.sv | 34 +++
 rtl/star_scan_engine.sv | 144 ++++++++++++++
 tb/tb_star_scan_engine.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/star_scan_engine_if.sv
// Pixel-scan bus between the star scan engine, the image RAM read port,
// the scan controller and the downstream star-handling chain.
interface star_scan_engine_if #(
  parameter int X_SZ    = 8,
  parameter int Y_SZ    = 7,
  parameter int ADDR_SZ = 15,
  parameter int COL_SZ  = 3,
  parameter int CNT_SZ  = 8
);
  logic                go;
  logic                load_en;
  logic [X_SZ-1:0]     load_x;
  logic [Y_SZ-1:0]     load_y;
  logic [COL_SZ-1:0]   pix_data;
  logic                star_ack;
  logic                rd_en;
  logic [ADDR_SZ-1:0]  addr_out;
  logic [X_SZ-1:0]     x_out;
  logic [Y_SZ-1:0]     y_out;
  logic                star_found;
  logic                busy;
  logic                scan_done;
  logic [CNT_SZ-1:0]   star_count;

  modport master (
    input  go, load_en, load_x, load_y, pix_data, star_ack,
    output rd_en, addr_out, x_out, y_out, star_found, busy, scan_done, star_count
  );

  modport slave (
    output go, load_en, load_x, load_y, pix_data, star_ack,
    input  rd_en, addr_out, x_out, y_out, star_found, busy, scan_done, star_count
  );
endinterface

// File: rtl/star_scan_engine.sv
// Row-major raster scanner: reads every pixel of the region with a fixed
// read latency and stalls on each threshold hit until downstream acknowledges.
module star_scan_engine #(
  parameter int                X_SZ      = 8,
  parameter int                Y_SZ      = 7,
  parameter int                MAX_X     = 160,
  parameter int                MAX_Y     = 120,
  parameter int                ADDR_SZ   = 15,
  parameter int                COL_SZ    = 3,
  parameter logic [COL_SZ-1:0] THRESHOLD = 3'd0,
  parameter logic [COL_SZ-1:0] MASK      = 3'b111,
  parameter int                RD_LAT    = 1,
  parameter int                CNT_SZ    = 8
) (
  input  logic               clk,
  input  logic               reset,
  star_scan_engine_if.master bus
);

  localparam logic [X_SZ-1:0]   LAST_X    = X_SZ'(MAX_X - 1);
  localparam logic [Y_SZ-1:0]   LAST_Y    = Y_SZ'(MAX_Y - 1);
  localparam logic [CNT_SZ-1:0] CNT_MAX   = {CNT_SZ{1'b1}};
  localparam int                WAIT_CYC  = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam logic [1:0]        WAIT_LAST = 2'(WAIT_CYC);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    FOUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [X_SZ-1:0]     x_r;
  logic [Y_SZ-1:0]     y_r;
  logic [CNT_SZ-1:0]   cnt_r;
  logic [1:0]          wait_r;
  logic                hit_s;
  logic                last_s;
  logic                load_ok_s;
  logic                adv_s;

  assign hit_s     = ((bus.pix_data & MASK) > THRESHOLD);
  assign last_s    = (x_r == LAST_X) && (y_r == LAST_Y);
  assign load_ok_s = ({1'b0, bus.load_x} < (X_SZ+1)'(MAX_X)) &&
                     ({1'b0, bus.load_y} < (Y_SZ+1)'(MAX_Y));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (bus.go) next_state_s = READ; else next_state_s = IDLE;
      READ:    if (RD_LAT > 1) next_state_s = WAIT; else next_state_s = CHECK;
      WAIT:    if (wait_r == WAIT_LAST) next_state_s = CHECK; else next_state_s = WAIT;
      CHECK: begin
        if (hit_s)       next_state_s = FOUND;
        else if (last_s) next_state_s = DONE;
        else             next_state_s = READ;
      end
      FOUND: begin
        if (!bus.star_ack) next_state_s = FOUND;
        else if (last_s)   next_state_s = DONE;
        else               next_state_s = READ;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // The hit pixel is skipped once acknowledged, never re-read
  always_comb begin
    adv_s = 1'b0;
    if (state_r == CHECK && !hit_s && !last_s) begin
      adv_s = 1'b1;
    end else if (state_r == FOUND && bus.star_ack && !last_s) begin
      adv_s = 1'b1;
    end else begin
      adv_s = 1'b0;
    end
  end

  // Scan position, latency counter and saturating hit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r    <= {X_SZ{1'b0}};
      y_r    <= {Y_SZ{1'b0}};
      cnt_r  <= {CNT_SZ{1'b0}};
      wait_r <= 2'd0;
    end else begin
      wait_r <= (state_r == WAIT) ? wait_r + 2'd1 : 2'd0;
      if (state_r == DONE) begin
        x_r <= {X_SZ{1'b0}};
        y_r <= {Y_SZ{1'b0}};
      end else if (adv_s) begin
        if (x_r == LAST_X) begin
          x_r <= {X_SZ{1'b0}};
          y_r <= y_r + Y_SZ'(1);
        end else begin
          x_r <= x_r + X_SZ'(1);
        end
      end else if (state_r == IDLE && bus.load_en && load_ok_s) begin
        x_r <= bus.load_x;
        y_r <= bus.load_y;
      end
      if (state_r == IDLE && bus.go) begin
        cnt_r <= {CNT_SZ{1'b0}};
      end else if (state_r == CHECK && hit_s && cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_SZ'(1);
      end
    end
  end

  // Output decode
  always_comb begin
    bus.rd_en      = 1'b0;
    bus.star_found = 1'b0;
    bus.scan_done  = 1'b0;
    bus.busy       = (state_r != IDLE);
    case (state_r)
      READ:    bus.rd_en      = 1'b1;
      FOUND:   bus.star_found = 1'b1;
      DONE:    bus.scan_done  = 1'b1;
      default: bus.rd_en      = 1'b0;
    endcase
  end

  assign bus.addr_out   = ADDR_SZ'(y_r) * ADDR_SZ'(MAX_X) + ADDR_SZ'(x_r);
  assign bus.x_out      = x_r;
  assign bus.y_out      = y_r;
  assign bus.star_count = cnt_r;

endmodule

// File: tb/tb_star_scan_engine.sv
// Bench for star_scan_engine: a pixel-level reference model checks the main
// instance every cycle; side instances cover masking, latency and a full frame.
module tb_star_scan_engine;

  localparam int MX   = 160;
  localparam int MY   = 120;
  localparam int NPIX = MX * MY;
  localparam int LAST = NPIX - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_main;
  logic rst_aux;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [2:0] img [NPIX];

  star_scan_engine_if m_if ();
  star_scan_engine_if f_if ();
  star_scan_engine_if k_if ();
  star_scan_engine_if #(.CNT_SZ(2)) l_if ();

  star_scan_engine u_dut  (.clk(clk), .reset(rst_main), .bus(m_if.master));
  star_scan_engine u_full (.clk(clk), .reset(rst_aux),  .bus(f_if.master));
  star_scan_engine #(.MAX_Y(2), .MASK(3'b100)) u_msk (.clk(clk), .reset(rst_aux), .bus(k_if.master));
  star_scan_engine #(.MAX_X(4), .MAX_Y(3), .RD_LAT(3), .CNT_SZ(2)) u_lat (.clk(clk), .reset(rst_aux), .bus(l_if.master));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Image RAM read ports; data is garbage except exactly RD_LAT cycles after a read
  logic [2:0] m_pd = 3'b111;
  logic [2:0] k_pd = 3'b111;
  logic [2:0] l_d [3];
  logic       l_v [3];

  function automatic logic [2:0] kimg(input int a);
    if (a == 159) return 3'b011;
    if (a == 165) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] limg(input int a);
    if (a == 1 || a == 3 || a == 6 || a == 8 || a == 11) return 3'b001;
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    m_pd    <= m_if.rd_en ? img[int'(m_if.addr_out)] : 3'b111;
    k_pd    <= k_if.rd_en ? kimg(int'(k_if.addr_out)) : 3'b111;
    l_d[0]  <= limg(int'(l_if.addr_out));
    l_v[0]  <= l_if.rd_en;
    l_d[1]  <= l_d[0];
    l_v[1]  <= l_v[0];
    l_d[2]  <= l_d[1];
    l_v[2]  <= l_v[1];
  end

  assign m_if.pix_data = m_pd;
  assign f_if.pix_data = 3'd0;
  assign k_if.pix_data = k_pd;
  assign l_if.pix_data = l_v[2] ? l_d[2] : 3'b111;

  // Reference model for u_dut: linear pixel index plus cycles spent on that pixel
  bit m_active = 1'b0;
  bit m_hold   = 1'b0;
  bit m_done   = 1'b0;
  int m_p      = 0;
  int m_t      = 0;
  int m_cnt    = 0;
  bit cmp_on   = 1'b0;

  always @(posedge clk) begin
    if (rst_main) begin
      m_active <= 1'b0; m_hold <= 1'b0; m_done <= 1'b0;
      m_p <= 0; m_t <= 0; m_cnt <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_p    <= 0;
    end else if (!m_active) begin
      if (m_if.load_en && int'(m_if.load_x) < MX && int'(m_if.load_y) < MY)
        m_p <= int'(m_if.load_y) * MX + int'(m_if.load_x);
      if (m_if.go) begin
        m_active <= 1'b1; m_t <= 0; m_cnt <= 0;
      end
    end else if (m_hold) begin
      if (m_if.star_ack) begin
        m_hold <= 1'b0;
        if (m_p == LAST) begin m_active <= 1'b0; m_done <= 1'b1; end
        else begin m_p <= m_p + 1; m_t <= 0; end
      end
    end else if (m_t < 1) begin
      m_t <= m_t + 1;
    end else if (img[m_p] != 3'd0) begin
      m_hold <= 1'b1;
      m_cnt  <= (m_cnt == 255) ? 255 : m_cnt + 1;
    end else if (m_p == LAST) begin
      m_active <= 1'b0; m_done <= 1'b1;
    end else begin
      m_p <= m_p + 1; m_t <= 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("rd_en",      int'(m_if.rd_en),      int'(m_active && !m_hold && m_t == 0));
      chk("star_found", int'(m_if.star_found), int'(m_hold));
      chk("busy",       int'(m_if.busy),       int'(m_active || m_done));
      chk("scan_done",  int'(m_if.scan_done),  int'(m_done));
      chk("star_count", int'(m_if.star_count), m_cnt);
      if (!m_done) begin
        chk("x_out",    int'(m_if.x_out),    m_p % MX);
        chk("y_out",    int'(m_if.y_out),    m_p / MX);
        chk("addr_out", int'(m_if.addr_out), m_p);
      end
    end
  end

  task automatic seq_main();
    int i;
    int rd_n;
    @(negedge clk); m_if.go = 1'b1;
    @(negedge clk); m_if.go = 1'b0;
    i = 0;
    while (!m_if.star_found && i < 2000) begin @(negedge clk); i++; end
    chk("s1_found", int'(m_if.star_found), 1);
    chk("s1_x", int'(m_if.x_out), 5);
    chk("s1_y", int'(m_if.y_out), 2);
    chk("s1_addr", int'(m_if.addr_out), 325);
    chk("s1_count", int'(m_if.star_count), 1);
    repeat (10) begin
      @(negedge clk);
      chk("hold_found", int'(m_if.star_found), 1);
      chk("hold_addr", int'(m_if.addr_out), 325);
      chk("hold_rd", int'(m_if.rd_en), 0);
    end
    m_if.star_ack = 1'b1;
    @(negedge clk); m_if.star_ack = 1'b0;
    chk("ack_rd", int'(m_if.rd_en), 1);
    chk("ack_addr", int'(m_if.addr_out), 326);
    i = 0;
    while (!m_if.scan_done && i < 40000) begin @(negedge clk); i++; end
    chk("s1_done", int'(m_if.scan_done), 1);
    chk("s1_final_count", int'(m_if.star_count), 1);

    // start-position load, including out-of-range loads that must be ignored
    img[LAST] = 3'd3;
    @(negedge clk);
    m_if.load_en = 1'b1; m_if.load_x = 8'd3; m_if.load_y = 7'd1;
    @(negedge clk);
    chk("load_ok_x", int'(m_if.x_out), 3);
    m_if.load_x = 8'd160; m_if.load_y = 7'd0;
    @(negedge clk);
    chk("load_badx", int'(m_if.x_out), 3);
    m_if.load_x = 8'd7; m_if.load_y = 7'd120;
    @(negedge clk);
    chk("load_bady", int'(m_if.y_out), 1);
    m_if.load_x = 8'd150; m_if.load_y = 7'd119; m_if.go = 1'b1;
    @(negedge clk); m_if.load_en = 1'b0; m_if.go = 1'b0;
    chk("ld_x", int'(m_if.x_out), 150);
    chk("ld_y", int'(m_if.y_out), 119);
    chk("ld_addr", int'(m_if.addr_out), 19190);
    rd_n = 0; i = 0;
    while (!m_if.star_found && i < 100) begin
      if (m_if.rd_en) rd_n++;
      @(negedge clk); i++;
    end
    chk("ld_reads", rd_n, 10);
    chk("ld_hit_addr", int'(m_if.addr_out), 19199);
    m_if.star_ack = 1'b1;
    @(negedge clk); m_if.star_ack = 1'b0;
    chk("ld_done", int'(m_if.scan_done), 1);
    chk("ld_done_rd", int'(m_if.rd_en), 0);
    repeat (3) begin @(negedge clk); chk("ld_no_rd", int'(m_if.rd_en), 0); end

    // reset while a star is pending
    m_if.go = 1'b1;
    @(negedge clk); m_if.go = 1'b0;
    i = 0;
    while (!m_if.star_found && i < 2000) begin @(negedge clk); i++; end
    chk("r_found", int'(m_if.star_found), 1);
    rst_main = 1'b1;
    @(negedge clk);
    chk("r_found_drop", int'(m_if.star_found), 0);
    chk("r_count", int'(m_if.star_count), 0);
    chk("r_addr", int'(m_if.addr_out), 0);
    chk("r_busy", int'(m_if.busy), 0);
    rst_main = 1'b0; m_if.go = 1'b1;
    @(negedge clk); m_if.go = 1'b0;
    chk("r_restart_rd", int'(m_if.rd_en), 1);
    chk("r_restart_addr", int'(m_if.addr_out), 0);
    rst_main = 1'b1;
    @(negedge clk); rst_main = 1'b0;
  endtask

  task automatic seq_full();
    int cyc;
    int rd_n = 0;
    int found_n = 0;
    @(negedge clk); f_if.go = 1'b1;
    @(negedge clk); f_if.go = 1'b0;
    cyc = 1;
    while (!f_if.scan_done && cyc < 40000) begin
      if (f_if.rd_en) rd_n++;
      if (f_if.star_found) found_n++;
      @(negedge clk); cyc++;
    end
    chk("full_done", int'(f_if.scan_done), 1);
    chk("full_done_cycle", cyc, 38401);
    chk("full_reads", rd_n, 19200);
    chk("full_found", found_n, 0);
    chk("full_count", int'(f_if.star_count), 0);
    chk("full_busy", int'(f_if.busy), 1);
  endtask

  task automatic seq_msk();
    int i = 0;
    int prev = -1;
    bit saw = 1'b0;
    @(negedge clk); k_if.go = 1'b1;
    @(negedge clk); k_if.go = 1'b0;
    while (!k_if.star_found && i < 1000) begin
      if (k_if.rd_en) begin
        if (int'(k_if.addr_out) == 160) begin
          saw = 1'b1;
          chk("msk_prev_addr", prev, 159);
          chk("msk_wrap_x", int'(k_if.x_out), 0);
          chk("msk_wrap_y", int'(k_if.y_out), 1);
        end
        prev = int'(k_if.addr_out);
      end
      @(negedge clk); i++;
    end
    chk("msk_wrap_seen", int'(saw), 1);
    chk("msk_hit_addr", int'(k_if.addr_out), 165);
    chk("msk_hit_x", int'(k_if.x_out), 5);
    chk("msk_count", int'(k_if.star_count), 1);
    k_if.star_ack = 1'b1;
    @(negedge clk); k_if.star_ack = 1'b0;
    i = 0;
    while (!k_if.scan_done && i < 1000) begin @(negedge clk); i++; end
    chk("msk_done", int'(k_if.scan_done), 1);
    chk("msk_final_count", int'(k_if.star_count), 1);
  endtask

  task automatic seq_lat();
    int rd_cyc [12];
    int hit_cnt [5];
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    int rd_n = 0;
    int hit_n = 0;
    int cyc = 1;
    bit done_seen = 1'b0;
    @(negedge clk); l_if.go = 1'b1;
    @(negedge clk); l_if.go = 1'b0;
    while (!done_seen && cyc < 200) begin
      if (l_if.rd_en) begin
        if (rd_n < 12) begin
          rd_cyc[rd_n] = cyc;
          chk("lat_rd_addr", int'(l_if.addr_out), rd_n);
        end
        rd_n++;
      end
      if (l_if.star_found) begin
        if (hit_n < 5) hit_cnt[hit_n] = int'(l_if.star_count);
        hit_n++;
        l_if.star_ack = 1'b1;
      end else begin
        l_if.star_ack = 1'b0;
      end
      l_if.go      = (cyc >= 3 && cyc < 20);
      l_if.load_en = (cyc >= 3 && cyc < 20);
      done_seen    = l_if.scan_done;
      if (!done_seen) begin @(negedge clk); cyc++; end
    end
    l_if.go = 1'b0; l_if.load_en = 1'b0; l_if.star_ack = 1'b0;
    chk("lat_done", int'(done_seen), 1);
    chk("lat_reads", rd_n, 12);
    chk("lat_hits", hit_n, 5);
    if (rd_n >= 12) begin
      chk("lat_pix_cycles_0", rd_cyc[1] - rd_cyc[0], 4);
      chk("lat_pix_cycles_4", rd_cyc[5] - rd_cyc[4], 4);
      chk("lat_hit_cycles_1", rd_cyc[2] - rd_cyc[1], 5);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < hit_n) chk("lat_sat_count", hit_cnt[k], exp_cnt[k]);
    end
    chk("lat_final_count", int'(l_if.star_count), 3);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) img[i] = 3'd0;
    img[2 * MX + 5] = 3'd3;
    m_if.go = 1'b0; m_if.load_en = 1'b0; m_if.load_x = 8'd0; m_if.load_y = 7'd0; m_if.star_ack = 1'b0;
    f_if.go = 1'b0; f_if.load_en = 1'b0; f_if.load_x = 8'd0; f_if.load_y = 7'd0; f_if.star_ack = 1'b0;
    k_if.go = 1'b0; k_if.load_en = 1'b0; k_if.load_x = 8'd0; k_if.load_y = 7'd0; k_if.star_ack = 1'b0;
    l_if.go = 1'b0; l_if.load_en = 1'b0; l_if.load_x = 8'd0; l_if.load_y = 7'd0; l_if.star_ack = 1'b0;
    rst_main = 1'b1;
    rst_aux  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(m_if.busy), 0);
    chk("rst_found", int'(m_if.star_found), 0);
    chk("rst_addr", int'(m_if.addr_out), 0);
    chk("rst_count", int'(m_if.star_count), 0);
    chk("rst_rd", int'(m_if.rd_en), 0);
    rst_main = 1'b0;
    rst_aux  = 1'b0;
    cmp_on   = 1'b1;
    fork
      seq_main();
      seq_full();
      seq_msk();
      seq_lat();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
